// File: rtl/adder_rr_arbiter.sv
// Round-robin arbiter that shares one W-bit adder between NREQ requesters through a one-entry result slot.
// Optional ADDER_RR_SAT_EN: unsigned saturation of res_data on carry-out.
module adder_rr_arbiter #(
   parameter int W    = 8,
   parameter int NREQ = 4,
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*W-1:0] a_flat,
   input  logic [NREQ*W-1:0] b_flat,
   output logic [NREQ-1:0]   gnt,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [W-1:0]      res_data,
   output logic              res_carry,
   output logic [IDW-1:0]    res_id,
   output logic              busy
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t         state, state_nxt;
   logic [IDW-1:0] rr_ptr;
   logic           slot_free;
   logic           grant;
   logic [IDW-1:0] win_idx;
   logic [W-1:0]   a_sel, b_sel;
   logic [W:0]     sum_p0;
   logic [W-1:0]   data_p1;
   logic           carry_p1;
   logic [IDW-1:0] id_p1;

   function automatic logic [W-1:0] fit_sum(input logic [W:0] s);
`ifdef ADDER_RR_SAT_EN
      return s[W] ? {W{1'b1}} : s[W-1:0];
`else
      return s[W-1:0];
`endif
   endfunction

   assign slot_free = (state == EMPTY) | res_ready;

   // Scan offsets from high to low so the last hit is the nearest requester at or after rr_ptr.
   always_comb begin
      gnt     = '0;
      grant   = 1'b0;
      win_idx = '0;
      if (rst_n && slot_free) begin
         for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[(int'(rr_ptr) + i) % NREQ]) begin
               grant   = 1'b1;
               win_idx = IDW'((int'(rr_ptr) + i) % NREQ);
            end
         end
         if (grant) gnt[win_idx] = 1'b1;
      end
   end

   // ---- stage p0: operand select and add in the grant cycle ----
   assign a_sel  = a_flat[win_idx*W +: W];
   assign b_sel  = b_flat[win_idx*W +: W];
   assign sum_p0 = {1'b0, a_sel} + {1'b0, b_sel};

   always_comb begin
      state_nxt = state;
      case (state)
         EMPTY:   if (grant) state_nxt = FULL;
         FULL:    if (res_ready && !grant) state_nxt = EMPTY;
         default: state_nxt = EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= EMPTY;
         rr_ptr <= '0;
      end else begin
         state <= state_nxt;
         if (grant) rr_ptr <= (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
      end
   end

   // ---- stage p1: result slot ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_p1  <= '0;
         carry_p1 <= 1'b0;
         id_p1    <= '0;
      end else if (grant) begin
         data_p1  <= fit_sum(sum_p0);
         carry_p1 <= sum_p0[W];
         id_p1    <= win_idx;
      end
   end

   assign res_valid = (state == FULL);
   assign res_data  = data_p1;
   assign res_carry = carry_p1;
   assign res_id    = id_p1;
   assign busy      = (|req) | res_valid;

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Randomized and directed bench for adder_rr_arbiter against a cycle-level reference model.
module tb_adder_rr_arbiter;
   localparam int W    = 8;
   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NREQ-1:0]   req;
   logic [NREQ*W-1:0] a_flat, b_flat;
   logic [NREQ-1:0]   gnt;
   logic              res_valid, res_ready, res_carry, busy;
   logic [W-1:0]      res_data;
   logic [IDW-1:0]    res_id;

   int checks = 0;
   int errors = 0;

   int m_ptr, m_data, m_carry, m_id;
   bit m_valid;

   adder_rr_arbiter #(.W(W), .NREQ(NREQ)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .a_flat(a_flat), .b_flat(b_flat),
      .gnt(gnt), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_carry(res_carry), .res_id(res_id), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference arbitration: first asserted request at or after the pointer, with wrap.
   function automatic int model_pick(input logic [NREQ-1:0] r, input logic rdy);
      if (m_valid && !rdy) return -1;
      for (int i = 0; i < NREQ; i++)
         if (r[(m_ptr + i) % NREQ]) return (m_ptr + i) % NREQ;
      return -1;
   endfunction

   task automatic model_reset();
      m_ptr = 0; m_valid = 0; m_data = 0; m_carry = 0; m_id = 0;
   endtask

   // One clock: drive inputs, check gnt/busy before the edge, update model, check slot after it.
   task automatic step(input logic [NREQ-1:0] r, input logic [NREQ*W-1:0] a,
                       input logic [NREQ*W-1:0] b, input logic rdy);
      int k, s;
      logic [NREQ-1:0] eg;
      req = r; a_flat = a; b_flat = b; res_ready = rdy;
      #1;
      k  = model_pick(r, rdy);
      eg = '0;
      if (k >= 0) eg[k] = 1'b1;
      check_eq("gnt", gnt, eg);
      check_eq("busy", busy, (r != 0) || m_valid);
      @(posedge clk);
      if (k >= 0) begin
         s       = int'(a[k*W +: W]) + int'(b[k*W +: W]);
         m_carry = (s >= (1 << W)) ? 1 : 0;
         m_data  = s % (1 << W);
`ifdef ADDER_RR_SAT_EN
         if (m_carry == 1) m_data = (1 << W) - 1;
`endif
         m_id    = k;
         m_valid = 1;
         m_ptr   = (k + 1) % NREQ;
      end else if (rdy) begin
         m_valid = 0;
      end
      #1;
      check_eq("res_valid", res_valid, m_valid);
      check_eq("res_data", res_data, m_data);
      check_eq("res_carry", res_carry, m_carry);
      check_eq("res_id", res_id, m_id);
   endtask

   // Asynchronous reset applied between edges; returns on a falling edge after release.
   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      #1;
      check_eq("rst_valid", res_valid, 0);
      check_eq("rst_gnt", gnt, 0);
      @(posedge clk);
      #1;
      check_eq("rst_hold_valid", res_valid, 0);
      check_eq("rst_data", res_data, 0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; req = '1; a_flat = '0; b_flat = '0; res_ready = 1'b1;
      model_reset();
      #2;
      check_eq("init_valid", res_valid, 0);
      check_eq("init_data", res_data, 0);
      check_eq("init_carry", res_carry, 0);
      check_eq("init_id", res_id, 0);
      check_eq("init_gnt", gnt, 0);
      #10;
      @(negedge clk);
      rst_n = 1'b1;

      // Single transfer from requester 0
      step(4'b0001, 32'h0000_0012, 32'h0000_0034, 1'b1);
      check_eq("t1_data", res_data, 8'h46);
      check_eq("t1_id", res_id, 0);

      // All requesting: strict rotation from pointer 0
      @(posedge clk); #1;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         step(4'b1111, $urandom, $urandom, 1'b1);
         check_eq("t2_id", res_id, i % NREQ);
      end

      // Overflow
      step(4'b0001, 32'h0000_00FF, 32'h0000_0002, 1'b1);
      check_eq("t3_carry", res_carry, 1);
`ifdef ADDER_RR_SAT_EN
      check_eq("t3_data", res_data, 8'hFF);
`else
      check_eq("t3_data", res_data, 8'h01);
`endif

      // Backpressure with a waiting requester
      for (int i = 0; i < 3; i++) step(4'b0100, $urandom, $urandom, 1'b0);
      step(4'b0100, 32'h0011_0000, 32'h0022_0000, 1'b1);
      check_eq("t4_data", res_data, 8'h33);
      check_eq("t4_id", res_id, 2);

      // Pointer wrap
      @(posedge clk); #1;
      do_reset();
      step(4'b1000, $urandom, $urandom, 1'b1);
      step(4'b1001, $urandom, $urandom, 1'b1);
      check_eq("t5_id0", res_id, 0);
      step(4'b1001, $urandom, $urandom, 1'b1);
      check_eq("t5_id3", res_id, 3);

      // Reset while FULL with a pending request
      step(4'b0010, $urandom, $urandom, 1'b0);
      do_reset();
      step(4'b0010, $urandom, $urandom, 1'b1);
      check_eq("t6_id", res_id, 1);
      step(4'b1111, $urandom, $urandom, 1'b1);
      check_eq("t6_ptr", res_id, 2);

      // Random traffic with occasional resets
      for (int n = 0; n < 400; n++) begin
         step(4'($urandom_range(0, 15)), $urandom, $urandom, ($urandom_range(0, 3) != 0));
         if ($urandom_range(0, 63) == 0) do_reset();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
